// File: rtl/control_unit_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle main control unit:
//   - state_t      : FSM state encodings (also visible on state_dbg)
//   - OP_* / FN_*  : opcode (IR[31:26]) and funct (IR[5:0]) values decoded
//   - ALU_*        : alu_op function codes driven to the ALU
//   - SRCB_* / PCSRC_* : mux select codes for ALU operand B and PC source
//   - helpers      : R-type legality, add/sub detection, funct -> alu_op
// ----------------------------------------------------------------------------
package ctrl_pkg;

    // Wide enough for the largest legal wait count (7).
    localparam int CNT_W = 3;

    typedef enum logic [4:0] {
        ST_RST     = 5'd0,
        ST_FETCH   = 5'd1,
        ST_DECODE  = 5'd2,
        ST_EXEC_R  = 5'd3,
        ST_WB_R    = 5'd4,
        ST_EXEC_I  = 5'd5,
        ST_WB_I    = 5'd6,
        ST_ADDR    = 5'd7,
        ST_MEM_RD  = 5'd8,
        ST_WB_LW   = 5'd9,
        ST_MEM_WR  = 5'd10,
        ST_BRANCH  = 5'd11,
        ST_JUMP    = 5'd12,
        ST_OVF     = 5'd13,
        ST_ILLEGAL = 5'd14
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    // ALU function codes
    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    // ALU operand B select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic rtype_legal(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) ||
               (funct == FN_AND) || (funct == FN_OR);
    endfunction

    // Only add/sub can raise a signed overflow exception.
    function automatic logic rtype_arith(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

    function automatic logic [2:0] funct_to_aluop(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// ----------------------------------------------------------------------------
// control_unit_if
// Bundle between the main control unit and the datapath.
//   Datapath -> control : opcode, funct, zero, overflow
//   Control -> datapath : write strobes (pc_w, mem_w, ir_w, ab_w, alu_out_w,
//                         mdr_w, reg_w), mux selects (i_or_d, alu_src_a,
//                         alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg),
//                         exception (exc, exc_cause) and state_dbg.
// There is no handshake: the control unit is a Moore machine and every
// output is valid for the whole cycle it is asserted in; the datapath acts
// on strobes at the next rising clock edge.
// modport master : the control unit
// modport slave  : the datapath (or a testbench standing in for it)
// ----------------------------------------------------------------------------
interface control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;

    logic       pc_w;
    logic       mem_w;
    logic       ir_w;
    logic       ab_w;
    logic       alu_out_w;
    logic       mdr_w;
    logic       reg_w;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       exc;
    logic       exc_cause;
    logic [4:0] state_dbg;

    modport master (
        input  opcode, funct, zero, overflow,
        output pc_w, mem_w, ir_w, ab_w, alu_out_w, mdr_w, reg_w,
               i_or_d, alu_src_a, alu_src_b, alu_op, pc_src,
               reg_dst, mem_to_reg, exc, exc_cause, state_dbg
    );

    modport slave (
        output opcode, funct, zero, overflow,
        input  pc_w, mem_w, ir_w, ab_w, alu_out_w, mdr_w, reg_w,
               i_or_d, alu_src_a, alu_src_b, alu_op, pc_src,
               reg_dst, mem_to_reg, exc, exc_cause, state_dbg
    );
endinterface

// File: rtl/control_unit_mem_wait_counter.sv
// ----------------------------------------------------------------------------
// mem_wait_counter
// Counts the cycles a memory read address has been presented. Shared by the
// FETCH and MEM_RD states of the control unit.
//   clk, reset   : clock, synchronous active-high reset (count -> 0)
//   i_load       : restart at 0 (asserted on entry to a wait state)
//   i_en         : advance by one, saturating at MEM_WAIT
//   o_done       : current count has reached MEM_WAIT (last wait cycle)
//   o_next_done  : count after this edge will be MEM_WAIT; lets the FSM
//                  register the last-cycle strobes one cycle ahead
// MEM_WAIT legal range is 1..7.
// ----------------------------------------------------------------------------
module mem_wait_counter
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_done,
    output logic o_next_done
);

    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next_count;

    // Load wins over enable; the count never passes WAIT_MAX.
    always_comb begin
        w_next_count = r_count;
        if (i_load) begin
            w_next_count = '0;
        end else if (i_en && (r_count != WAIT_MAX)) begin
            w_next_count = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next_count;
        end
    end

    assign o_done      = (r_count == WAIT_MAX);
    assign o_next_done = (w_next_count == WAIT_MAX);

endmodule

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
// Multicycle main control FSM for the CPU datapath.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; forces RST and clears all outputs
//   cu     : control_unit_if.master
//            in : opcode, funct, zero, overflow
//            out: pc_w, mem_w, ir_w, ab_w, alu_out_w, mdr_w, reg_w, i_or_d,
//                 alu_src_a, alu_src_b, alu_op, pc_src, reg_dst,
//                 mem_to_reg, exc, exc_cause, state_dbg
// Outputs are registered and decoded from the state being entered, so they
// are a clean Moore function of the current state. The single exception is
// pc_w in BRANCH, which depends on the ALU zero flag of that same cycle.
// MEM_WAIT (1..7) is the number of wait cycles before memory read data is
// valid; FETCH and MEM_RD last MEM_WAIT+1 cycles.
// ----------------------------------------------------------------------------
module control_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master cu
);

    state_t     r_state;
    state_t     w_next_state;

    logic       r_pc_w;
    logic       r_mem_w;
    logic       r_ir_w;
    logic       r_ab_w;
    logic       r_alu_out_w;
    logic       r_mdr_w;
    logic       r_reg_w;
    logic       r_i_or_d;
    logic       r_alu_src_a;
    logic [1:0] r_alu_src_b;
    logic [2:0] r_alu_op;
    logic [1:0] r_pc_src;
    logic       r_reg_dst;
    logic       r_mem_to_reg;
    logic       r_exc;
    logic       r_exc_cause;

    logic       w_cnt_load;
    logic       w_cnt_en;
    logic       w_cnt_done;
    logic       w_cnt_next_done;
    logic       w_next_is_wait;
    logic       w_branch_take;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = ST_FETCH;
        case (r_state)
            ST_RST:    w_next_state = ST_FETCH;
            ST_FETCH:  w_next_state = w_cnt_done ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (cu.opcode)
                    OP_RTYPE: w_next_state = rtype_legal(cu.funct) ? ST_EXEC_R
                                                                   : ST_ILLEGAL;
                    OP_LW,
                    OP_SW:    w_next_state = ST_ADDR;
                    OP_BEQ,
                    OP_BNE:   w_next_state = ST_BRANCH;
                    OP_J:     w_next_state = ST_JUMP;
                    OP_ADDI:  w_next_state = ST_EXEC_I;
                    default:  w_next_state = ST_ILLEGAL;
                endcase
            end
            // and/or never trap, whatever the overflow flag says.
            ST_EXEC_R: w_next_state = (cu.overflow && rtype_arith(cu.funct))
                                      ? ST_OVF : ST_WB_R;
            ST_EXEC_I: w_next_state = cu.overflow ? ST_OVF : ST_WB_I;
            ST_ADDR:   w_next_state = (cu.opcode == OP_LW) ? ST_MEM_RD
                                                           : ST_MEM_WR;
            ST_MEM_RD: w_next_state = w_cnt_done ? ST_WB_LW : ST_MEM_RD;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counter: restarted on entry to FETCH/MEM_RD, advanced while the
    // FSM stays in the same wait state.
    // ------------------------------------------------------------------
    assign w_next_is_wait = (w_next_state == ST_FETCH) ||
                            (w_next_state == ST_MEM_RD);
    assign w_cnt_load     = w_next_is_wait && (w_next_state != r_state);
    assign w_cnt_en       = w_next_is_wait && (w_next_state == r_state);

    mem_wait_counter #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_cnt_load),
        .i_en        (w_cnt_en),
        .o_done      (w_cnt_done),
        .o_next_done (w_cnt_next_done)
    );

    // ------------------------------------------------------------------
    // State register and registered outputs. Outputs are computed from
    // the state being entered so they line up with r_state. Every output
    // defaults to 0 each cycle; exc_cause alone is held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RST;
            r_pc_w       <= 1'b0;
            r_mem_w      <= 1'b0;
            r_ir_w       <= 1'b0;
            r_ab_w       <= 1'b0;
            r_alu_out_w  <= 1'b0;
            r_mdr_w      <= 1'b0;
            r_reg_w      <= 1'b0;
            r_i_or_d     <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= SRCB_B;
            r_alu_op     <= ALU_NOP;
            r_pc_src     <= PCSRC_ALU;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_exc        <= 1'b0;
            r_exc_cause  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_pc_w       <= 1'b0;
            r_mem_w      <= 1'b0;
            r_ir_w       <= 1'b0;
            r_ab_w       <= 1'b0;
            r_alu_out_w  <= 1'b0;
            r_mdr_w      <= 1'b0;
            r_reg_w      <= 1'b0;
            r_i_or_d     <= 1'b0;
            r_alu_src_a  <= 1'b0;
            r_alu_src_b  <= SRCB_B;
            r_alu_op     <= ALU_NOP;
            r_pc_src     <= PCSRC_ALU;
            r_reg_dst    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_exc        <= 1'b0;

            case (w_next_state)
                ST_FETCH: begin
                    // Address is the PC throughout; on the data-valid cycle
                    // latch IR and advance PC by 4.
                    if (w_cnt_next_done) begin
                        r_ir_w      <= 1'b1;
                        r_pc_w      <= 1'b1;
                        r_alu_src_b <= SRCB_FOUR;
                        r_alu_op    <= ALU_ADD;
                    end
                end
                ST_DECODE: begin
                    // Branch target PC+4 + (imm<<2) precomputed into ALUOut.
                    r_ab_w      <= 1'b1;
                    r_alu_out_w <= 1'b1;
                    r_alu_src_b <= SRCB_IMM_SH;
                    r_alu_op    <= ALU_ADD;
                end
                ST_EXEC_R: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= SRCB_B;
                    r_alu_op    <= funct_to_aluop(cu.funct);
                    r_alu_out_w <= 1'b1;
                end
                ST_WB_R: begin
                    r_reg_dst <= 1'b1;
                    r_reg_w   <= 1'b1;
                end
                ST_EXEC_I,
                ST_ADDR: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= SRCB_IMM;
                    r_alu_op    <= ALU_ADD;
                    r_alu_out_w <= 1'b1;
                end
                ST_WB_I: begin
                    r_reg_w <= 1'b1;
                end
                ST_MEM_RD: begin
                    r_i_or_d <= 1'b1;
                    r_mdr_w  <= w_cnt_next_done;
                end
                ST_WB_LW: begin
                    r_mem_to_reg <= 1'b1;
                    r_reg_w      <= 1'b1;
                end
                ST_MEM_WR: begin
                    r_i_or_d <= 1'b1;
                    r_mem_w  <= 1'b1;
                end
                ST_BRANCH: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= SRCB_B;
                    r_alu_op    <= ALU_SUB;
                    r_pc_src    <= PCSRC_ALUOUT;
                end
                ST_JUMP: begin
                    r_pc_src <= PCSRC_JUMP;
                    r_pc_w   <= 1'b1;
                end
                ST_OVF: begin
                    r_exc       <= 1'b1;
                    r_exc_cause <= 1'b1;
                end
                ST_ILLEGAL: begin
                    // PC already points past the bad instruction.
                    r_exc       <= 1'b1;
                    r_exc_cause <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The branch decision needs the zero flag of the SUB computed in
    // BRANCH itself, so it cannot be registered ahead of time.
    assign w_branch_take = (r_state == ST_BRANCH) &&
                           ((cu.opcode == OP_BNE) ? ~cu.zero : cu.zero);

    assign cu.pc_w       = r_pc_w | w_branch_take;
    assign cu.mem_w      = r_mem_w;
    assign cu.ir_w       = r_ir_w;
    assign cu.ab_w       = r_ab_w;
    assign cu.alu_out_w  = r_alu_out_w;
    assign cu.mdr_w      = r_mdr_w;
    assign cu.reg_w      = r_reg_w;
    assign cu.i_or_d     = r_i_or_d;
    assign cu.alu_src_a  = r_alu_src_a;
    assign cu.alu_src_b  = r_alu_src_b;
    assign cu.alu_op     = r_alu_op;
    assign cu.pc_src     = r_pc_src;
    assign cu.reg_dst    = r_reg_dst;
    assign cu.mem_to_reg = r_mem_to_reg;
    assign cu.exc        = r_exc;
    assign cu.exc_cause  = r_exc_cause;
    assign cu.state_dbg  = r_state;

endmodule

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit. Two instances share clock, reset and
// instruction inputs: dut1 with MEM_WAIT=1 and dut3 with MEM_WAIT=3.
// Each test walks an instruction cycle by cycle against hand-written
// expected state, output vector and exc_cause.
// ----------------------------------------------------------------------------
module tb_control_unit;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       pc_w;
        logic       mem_w;
        logic       ir_w;
        logic       ab_w;
        logic       alu_out_w;
        logic       mdr_w;
        logic       reg_w;
        logic       i_or_d;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       exc;
    } ctl_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    control_unit_if if1 ();
    control_unit_if if3 ();

    control_unit #(.MEM_WAIT(1)) dut1 (.clk(clk), .reset(reset), .cu(if1));
    control_unit #(.MEM_WAIT(3)) dut3 (.clk(clk), .reset(reset), .cu(if3));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- output sampling ----------------
    ctl_t w_c1, w_c3;
    assign w_c1 = {if1.pc_w, if1.mem_w, if1.ir_w, if1.ab_w, if1.alu_out_w,
                   if1.mdr_w, if1.reg_w, if1.i_or_d, if1.alu_src_a,
                   if1.alu_src_b, if1.alu_op, if1.pc_src, if1.reg_dst,
                   if1.mem_to_reg, if1.exc};
    assign w_c3 = {if3.pc_w, if3.mem_w, if3.ir_w, if3.ab_w, if3.alu_out_w,
                   if3.mdr_w, if3.reg_w, if3.i_or_d, if3.alu_src_a,
                   if3.alu_src_b, if3.alu_op, if3.pc_src, if3.reg_dst,
                   if3.mem_to_reg, if3.exc};

    // Hand-written expected output vectors per state.
    ctl_t C_Z, C_F2, C_DEC, C_EXR_ADD, C_EXR_AND, C_WBR, C_EXI, C_WBI;
    ctl_t C_MRD, C_MRD_L, C_WBLW, C_MWR, C_BR0, C_BR1, C_J, C_EXC;

    // Expected sequence for the test in progress.
    state_t es[$];
    ctl_t   ec[$];
    logic   ek[$];

    task automatic init_vectors();
        C_Z = '0;
        C_F2 = '0;  C_F2.pc_w = 1'b1; C_F2.ir_w = 1'b1;
                    C_F2.alu_src_b = 2'b01; C_F2.alu_op = 3'b001;
        C_DEC = '0; C_DEC.ab_w = 1'b1; C_DEC.alu_out_w = 1'b1;
                    C_DEC.alu_src_b = 2'b11; C_DEC.alu_op = 3'b001;
        C_EXR_ADD = '0; C_EXR_ADD.alu_out_w = 1'b1; C_EXR_ADD.alu_src_a = 1'b1;
                        C_EXR_ADD.alu_op = 3'b001;
        C_EXR_AND = '0; C_EXR_AND.alu_out_w = 1'b1; C_EXR_AND.alu_src_a = 1'b1;
                        C_EXR_AND.alu_op = 3'b011;
        C_WBR = '0; C_WBR.reg_w = 1'b1; C_WBR.reg_dst = 1'b1;
        C_EXI = '0; C_EXI.alu_out_w = 1'b1; C_EXI.alu_src_a = 1'b1;
                    C_EXI.alu_src_b = 2'b10; C_EXI.alu_op = 3'b001;
        C_WBI = '0; C_WBI.reg_w = 1'b1;
        C_MRD = '0; C_MRD.i_or_d = 1'b1;
        C_MRD_L = '0; C_MRD_L.i_or_d = 1'b1; C_MRD_L.mdr_w = 1'b1;
        C_WBLW = '0; C_WBLW.reg_w = 1'b1; C_WBLW.mem_to_reg = 1'b1;
        C_MWR = '0; C_MWR.mem_w = 1'b1; C_MWR.i_or_d = 1'b1;
        C_BR0 = '0; C_BR0.alu_src_a = 1'b1; C_BR0.alu_op = 3'b010;
                    C_BR0.pc_src = 2'b01;
        C_BR1 = C_BR0; C_BR1.pc_w = 1'b1;
        C_J = '0;   C_J.pc_w = 1'b1; C_J.pc_src = 2'b10;
        C_EXC = '0; C_EXC.exc = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ov);
        if1.opcode = op;  if3.opcode = op;
        if1.funct  = fn;  if3.funct  = fn;
        if1.zero   = z;   if3.zero   = z;
        if1.overflow = ov; if3.overflow = ov;
    endtask

    // Leaves both DUTs in their first FETCH cycle.
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic clr_exp();
        es.delete(); ec.delete(); ek.delete();
    endtask

    task automatic add_exp(input state_t s, input ctl_t c, input logic k);
        es.push_back(s); ec.push_back(c); ek.push_back(k);
    endtask

    // FETCH(2 cycles) + DECODE for MEM_WAIT=1
    task automatic add_fetch1(input logic k);
        add_exp(ST_FETCH, C_Z, k);
        add_exp(ST_FETCH, C_F2, k);
        add_exp(ST_DECODE, C_DEC, k);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_instr(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (if1.state_dbg !== ST_RST) begin
                n_errors++;
                $display("FAIL reset state cyc%0d: got %0d want %0d", i, if1.state_dbg, ST_RST);
            end
            n_checks++;
            if (w_c1 !== C_Z) begin
                n_errors++;
                $display("FAIL reset outputs cyc%0d: got %h want %h", i, w_c1, C_Z);
            end
            n_checks++;
            if (if1.exc_cause !== 1'b0) begin
                n_errors++;
                $display("FAIL reset exc_cause cyc%0d: got %b want 0", i, if1.exc_cause);
            end
        end
        reset = 1'b0;
        clr_exp();
        add_fetch1(1'b0);
        for (int i = 0; i < es.size(); i++) begin
            tick();
            n_checks++;
            if (if1.state_dbg !== es[i]) begin
                n_errors++;
                $display("FAIL post_reset state cyc%0d: got %0d want %0d", i, if1.state_dbg, es[i]);
            end
            n_checks++;
            if (w_c1 !== ec[i]) begin
                n_errors++;
                $display("FAIL post_reset outputs cyc%0d: got %h want %h", i, w_c1, ec[i]);
            end
        end
    endtask

    task automatic test_rtype_add();
        do_reset();
        set_instr(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        clr_exp();
        add_fetch1(1'b0);
        add_exp(ST_EXEC_R, C_EXR_ADD, 1'b0);
        add_exp(ST_WB_R, C_WBR, 1'b0);
        add_exp(ST_FETCH, C_Z, 1'b0);
        // R-type and with overflow high: overflow ignored, writes back
        set_instr(OP_RTYPE, FN_AND, 1'b0, 1'b1);
        for (int i = 0; i < es.size(); i++) begin
            if (i == 0) set_instr(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
            n_checks++;
            if (if1.state_dbg !== es[i]) begin
                n_errors++;
                $display("FAIL r_add state cyc%0d: got %0d want %0d", i, if1.state_dbg, es[i]);
            end
            n_checks++;
            if (w_c1 !== ec[i]) begin
                n_errors++;
                $display("FAIL r_add outputs cyc%0d: got %h want %h", i, w_c1, ec[i]);
            end
            if (i != es.size() - 1) tick();
        end
        set_instr(OP_RTYPE, FN_AND, 1'b0, 1'b1);
        clr_exp();
        add_fetch1(1'b0);
        add_exp(ST_EXEC_R, C_EXR_AND, 1'b0);
        add_exp(ST_WB_R, C_WBR, 1'b0);
        add_exp(ST_FETCH, C_Z, 1'b0);
        for (int i = 0; i < es.size(); i++) begin
            n_checks++;
            if (if1.state_dbg !== es[i]) begin
                n_errors++;
                $display("FAIL r_and_ovf state cyc%0d: got %0d want %0d", i, if1.state_dbg, es[i]);
            end
            n_checks++;
            if (w_c1 !== ec[i]) begin
                n_errors++;
                $display("FAIL r_and_ovf outputs cyc%0d: got %h want %h", i, w_c1, ec[i]);
            end
            if (i != es.size() - 1) tick();
        end
    endtask

    task automatic test_mem_wait1();
        // lw (CPI 7) then sw (CPI 5)
        clr_exp();
        add_fetch1(1'b0);
        add_exp(ST_ADDR, C_EXI, 1'b0);
        add_exp(ST_MEM_RD, C_MRD, 1'b0);
        add_exp(ST_MEM_RD, C_MRD_L, 1'b0);
        add_exp(ST_WB_LW, C_WBLW, 1'b0);
        add_fetch1(1'b0);
        add_exp(ST_ADDR, C_EXI, 1'b0);
        add_exp(ST_MEM_WR, C_MWR, 1'b0);
        add_exp(ST_FETCH, C_Z, 1'b0);
        set_instr(OP_LW, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < es.size(); i++) begin
            if (i == 7) set_instr(OP_SW, 6'h00, 1'b0, 1'b0);
            n_checks++;
            if (if1.state_dbg !== es[i]) begin
                n_errors++;
                $display("FAIL lw_sw state cyc%0d: got %0d want %0d", i, if1.state_dbg, es[i]);
            end
            n_checks++;
            if (w_c1 !== ec[i]) begin
                n_errors++;
                $display("FAIL lw_sw outputs cyc%0d: got %h want %h", i, w_c1, ec[i]);
            end
            if (i != es.size() - 1) tick();
        end
    endtask

    task automatic test_lw_wait3();
        do_reset();
        set_instr(OP_LW, 6'h00, 1'b0, 1'b0);
        clr_exp();
        repeat (3) add_exp(ST_FETCH, C_Z, 1'b0);
        add_exp(ST_FETCH, C_F2, 1'b0);
        add_exp(ST_DECODE, C_DEC, 1'b0);
        add_exp(ST_ADDR, C_EXI, 1'b0);
        repeat (3) add_exp(ST_MEM_RD, C_MRD, 1'b0);
        add_exp(ST_MEM_RD, C_MRD_L, 1'b0);
        add_exp(ST_WB_LW, C_WBLW, 1'b0);
        add_exp(ST_FETCH, C_Z, 1'b0);
        for (int i = 0; i < es.size(); i++) begin
            n_checks++;
            if (if3.state_dbg !== es[i]) begin
                n_errors++;
                $display("FAIL lw_wait3 state cyc%0d: got %0d want %0d", i, if3.state_dbg, es[i]);
            end
            n_checks++;
            if (w_c3 !== ec[i]) begin
                n_errors++;
                $display("FAIL lw_wait3 outputs cyc%0d: got %h want %h", i, w_c3, ec[i]);
            end
            if (i != es.size() - 1) tick();
        end
    endtask

    task automatic test_branch_jump();
        do_reset();
        // beq z=1 (taken), beq z=0 (not taken), bne z=0 (taken), j
        clr_exp();
        add_fetch1(1'b0); add_exp(ST_BRANCH, C_BR1, 1'b0);
        add_fetch1(1'b0); add_exp(ST_BRANCH, C_BR0, 1'b0);
        add_fetch1(1'b0); add_exp(ST_BRANCH, C_BR1, 1'b0);
        add_fetch1(1'b0); add_exp(ST_JUMP, C_J, 1'b0);
        add_exp(ST_FETCH, C_Z, 1'b0);
        for (int i = 0; i < es.size(); i++) begin
            case (i)
                0:  set_instr(OP_BEQ, 6'h00, 1'b1, 1'b0);
                4:  set_instr(OP_BEQ, 6'h00, 1'b0, 1'b0);
                8:  set_instr(OP_BNE, 6'h00, 1'b0, 1'b0);
                12: set_instr(OP_J,   6'h00, 1'b0, 1'b0);
                default: ;
            endcase
            n_checks++;
            if (if1.state_dbg !== es[i]) begin
                n_errors++;
                $display("FAIL branch_jump state cyc%0d: got %0d want %0d", i, if1.state_dbg, es[i]);
            end
            n_checks++;
            if (w_c1 !== ec[i]) begin
                n_errors++;
                $display("FAIL branch_jump outputs cyc%0d: got %h want %h", i, w_c1, ec[i]);
            end
            if (i != es.size() - 1) tick();
        end
    endtask

    task automatic test_exceptions();
        // addi ok, addi overflow, add overflow, opcode 0x3F, R-type funct 0x2A
        clr_exp();
        add_fetch1(1'b0); add_exp(ST_EXEC_I, C_EXI, 1'b0); add_exp(ST_WB_I, C_WBI, 1'b0);
        add_fetch1(1'b0); add_exp(ST_EXEC_I, C_EXI, 1'b0); add_exp(ST_OVF, C_EXC, 1'b1);
        add_fetch1(1'b1); add_exp(ST_EXEC_R, C_EXR_ADD, 1'b1); add_exp(ST_OVF, C_EXC, 1'b1);
        add_fetch1(1'b1); add_exp(ST_ILLEGAL, C_EXC, 1'b0);
        add_fetch1(1'b0); add_exp(ST_ILLEGAL, C_EXC, 1'b0);
        add_exp(ST_FETCH, C_Z, 1'b0);
        for (int i = 0; i < es.size(); i++) begin
            case (i)
                0:  set_instr(OP_ADDI,  6'h00,  1'b0, 1'b0);
                5:  set_instr(OP_ADDI,  6'h00,  1'b0, 1'b1);
                10: set_instr(OP_RTYPE, FN_ADD, 1'b0, 1'b1);
                15: set_instr(6'h3F,    6'h00,  1'b0, 1'b0);
                19: set_instr(OP_RTYPE, 6'h2A,  1'b0, 1'b0);
                default: ;
            endcase
            n_checks++;
            if (if1.state_dbg !== es[i]) begin
                n_errors++;
                $display("FAIL exceptions state cyc%0d: got %0d want %0d", i, if1.state_dbg, es[i]);
            end
            n_checks++;
            if (w_c1 !== ec[i]) begin
                n_errors++;
                $display("FAIL exceptions outputs cyc%0d: got %h want %h", i, w_c1, ec[i]);
            end
            n_checks++;
            if (if1.exc_cause !== ek[i]) begin
                n_errors++;
                $display("FAIL exceptions exc_cause cyc%0d: got %b want %b", i, if1.exc_cause, ek[i]);
            end
            if (i != es.size() - 1) tick();
        end
    endtask

    task automatic test_reset_mid_memrd();
        // Overflow sets exc_cause, then lw is interrupted in MEM_RD.
        clr_exp();
        add_fetch1(1'b0); add_exp(ST_EXEC_I, C_EXI, 1'b0); add_exp(ST_OVF, C_EXC, 1'b1);
        add_fetch1(1'b1); add_exp(ST_ADDR, C_EXI, 1'b1); add_exp(ST_MEM_RD, C_MRD, 1'b1);
        for (int i = 0; i < es.size(); i++) begin
            if (i == 0) set_instr(OP_ADDI, 6'h00, 1'b0, 1'b1);
            if (i == 5) set_instr(OP_LW,   6'h00, 1'b0, 1'b0);
            n_checks++;
            if (if1.state_dbg !== es[i]) begin
                n_errors++;
                $display("FAIL reset_mid state cyc%0d: got %0d want %0d", i, if1.state_dbg, es[i]);
            end
            n_checks++;
            if (w_c1 !== ec[i]) begin
                n_errors++;
                $display("FAIL reset_mid outputs cyc%0d: got %h want %h", i, w_c1, ec[i]);
            end
            n_checks++;
            if (if1.exc_cause !== ek[i]) begin
                n_errors++;
                $display("FAIL reset_mid exc_cause cyc%0d: got %b want %b", i, if1.exc_cause, ek[i]);
            end
            if (i != es.size() - 1) tick();
        end
        // Reset during the first MEM_RD cycle: the mdr_w that would have
        // come next must not appear.
        reset = 1'b1;
        tick();
        n_checks++;
        if (if1.state_dbg !== ST_RST) begin
            n_errors++;
            $display("FAIL reset_mid rst_state: got %0d want %0d", if1.state_dbg, ST_RST);
        end
        n_checks++;
        if (w_c1 !== C_Z) begin
            n_errors++;
            $display("FAIL reset_mid rst_outputs: got %h want %h", w_c1, C_Z);
        end
        n_checks++;
        if (if1.exc_cause !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid rst_exc_cause: got %b want 0", if1.exc_cause);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (if1.state_dbg !== ST_FETCH || w_c1 !== C_Z) begin
            n_errors++;
            $display("FAIL reset_mid after_release: state %0d outputs %h want state %0d outputs %h",
                     if1.state_dbg, w_c1, ST_FETCH, C_Z);
        end
        tick();
        n_checks++;
        if (if1.state_dbg !== ST_FETCH || w_c1 !== C_F2) begin
            n_errors++;
            $display("FAIL reset_mid refetch: state %0d outputs %h want state %0d outputs %h",
                     if1.state_dbg, w_c1, ST_FETCH, C_F2);
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset = 1'b1;
        set_instr(6'h00, 6'h00, 1'b0, 1'b0);
        init_vectors();
        test_reset();
        test_rtype_add();
        test_mem_wait1();
        test_lw_wait3();
        test_branch_jump();
        test_exceptions();
        test_reset_mid_memrd();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
